// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word load-store front end for a word-only
// data memory. Sub-word stores are done as read-modify-write; loads are
// lane-selected and sign/zero extended before the one-cycle response.
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;

  logic        legal_f3;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [31:0] word_addr;
  logic [31:0] merged;
  logic [31:0] load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Classify the incoming request; only meaningful in IDLE when it is accepted.
  always_comb begin
    legal_f3     = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    if (req_we) begin
      // stores: SB, SH, SW only
      legal_f3 = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
    end else begin
      // loads: B, H, W, BU, HU
      legal_f3 = (req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]);
    end
    if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
      misaligned = 1'b1;
    end
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
      misaligned = 1'b1;
    end
    out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);
    req_err      = !legal_f3 || misaligned || out_of_range;
  end

  // Next state and request latching.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    err_d    = err_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = req_err;
          if (req_err) begin
            state_d = RESP;
          end else if (!req_we) begin
            state_d = RD;
          end else if (req_funct3[1:0] == 2'b10) begin
            state_d = WR;
          end else begin
            state_d = RD;  // sub-word store needs the old word first
          end
        end
      end
      RD: begin
        word_d  = mem_rd;
        state_d = we_q ? WR : RESP;
      end
      WR: begin
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lane merge for stores and lane extract/extend for loads.
  always_comb begin
    word_addr = {addr_q[31:2], 2'b00};
    byte_sel  = word_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = word_q[{addr_q[1], 4'b0000} +: 16];
    merged    = word_q;
    case (funct3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h000000, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0000, half_sel};
      default: load_data = word_q;
    endcase
  end

  // Outputs decoded from the current state so reset clears them at once.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    mem_we     = 1'b0;
    mem_a      = 32'h0;
    mem_wd     = 32'h0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      RD:   mem_a = word_addr;
      WR: begin
        mem_we = 1'b1;
        mem_a  = word_addr;
        mem_wd = merged;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !we_q) begin
          resp_rdata = load_data;
        end
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      word_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      err_q    <= err_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: an attached word memory, a per-cycle expected
// output schedule built from the request rules, directed literal cases and
// randomized traffic.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Attached data memory (combinational read, write at clock edge).
  logic [31:0] sim_mem [64];
  logic        sim_clr = 1'b0;
  always @(posedge clk) begin
    if (!sim_clr) begin
      for (int i = 0; i < 64; i++) sim_mem[i] <= 32'h0;
      sim_clr <= 1'b1;
    end else if (mem_we && (mem_a[31:8] == 24'h0)) begin
      sim_mem[mem_a[7:2]] <= mem_wd;
    end
  end
  assign mem_rd = (mem_a[31:8] == 24'h0) ? sim_mem[mem_a[7:2]] : 32'h0;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h required %h", nm, $time, got, expv);
    end
  endfunction

  // Expected outputs for one cycle.
  typedef struct packed {
    logic        ready;
    logic        we;
    logic        rv;
    logic        err;
    logic        chkwd;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  function automatic exp_t mk(input logic ready, input logic we, input logic rv, input logic err,
                              input logic chkwd, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd);
    exp_t e;
    e.ready = ready; e.we = we; e.rv = rv; e.err = err; e.chkwd = chkwd;
    e.a = a; e.wd = wd; e.rd = rd;
    return e;
  endfunction

  exp_t        exp_q[$];
  logic [31:0] ref_mem [64];
  logic        ref_clr = 1'b0;

  // Build the expected cycle-by-cycle schedule of one accepted request.
  task automatic plan(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd);
    int          sz;
    int          off;
    bit          legal;
    bit          bad;
    logic [31:0] wa, old, v, nw;
    logic [63:0] lmask;
    sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
    bad   = !legal || ((addr % sz) != 0) || ((addr >> 2) >= 64);
    wa    = addr & ~32'h3;
    off   = int'(addr[1:0]);
    lmask = (64'd1 << (8 * sz)) - 64'd1;
    if (bad) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0));
    end else begin
      old = ref_mem[addr[7:2]];
      if (!we) begin
        v = 32'((64'(old) >> (8 * off)) & lmask);
        if (!f3[2] && (sz < 4) && v[8 * sz - 1]) v = v | ~32'(lmask);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, wa, 32'h0, 32'h0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, v));
      end else begin
        if (sz == 4) begin
          nw = wd;
        end else begin
          nw = 32'((64'(old) & ~(lmask << (8 * off))) | ((64'(wd) & lmask) << (8 * off)));
          exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, wa, 32'h0, 32'h0));
        end
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, wa, nw, 32'h0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0));
      end
    end
    // the mandatory idle cycle before the next accept
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0));
  endtask

  // Reference model: retire the cycle that just ended, then accept if free.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      if (!ref_clr) begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        ref_clr = 1'b1;
      end
    end else begin
      if (exp_q.size() > 0) begin
        if (exp_q[0].we) ref_mem[exp_q[0].a[7:2]] = exp_q[0].wd;
        void'(exp_q.pop_front());
      end
      if ((exp_q.size() == 0) && req_valid) plan(req_we, req_funct3, req_addr, req_wdata);
    end
  end

  // Per-cycle compare against the schedule, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) e = exp_q[0];
    else e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    chk("cyc_req_ready", 32'(req_ready), 32'(e.ready));
    chk("cyc_mem_we", 32'(mem_we), 32'(e.we));
    chk("cyc_mem_a", mem_a, e.a);
    if (e.chkwd) chk("cyc_mem_wd", mem_wd, e.wd);
    chk("cyc_resp_valid", 32'(resp_valid), 32'(e.rv));
    if (e.rv) begin
      chk("cyc_resp_rdata", resp_rdata, e.rd);
      chk("cyc_resp_err", 32'(resp_err), 32'(e.err));
    end
  end

  // Issue one request, wait for its response; k counts cycles after the accept edge.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int wc, output logic [31:0] wdat);
    int waited;
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    while (!req_ready && (waited < 20)) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_wait", 32'(req_ready), 32'd1);
    rd = 32'h0; er = 1'b0; lat = -1; wc = -1; wdat = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
      end
      if (mem_we && (wc < 0)) begin
        wc = k;
        wdat = mem_wd;
      end
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_err;
        break;
      end
    end
  endtask

  task automatic dreq(input string nm, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_err, input int exp_lat, input int exp_wc,
                      input logic [31:0] exp_wd);
    logic [31:0] rd, wdat;
    logic        er;
    int          lat, wc;
    do_req(we, f3, addr, wd, rd, er, lat, wc, wdat);
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, 32'(er), 32'(exp_err));
    chk({nm, "_we_cycle"}, 32'(wc), 32'(exp_wc));
    if (exp_wc > 0) chk({nm, "_mem_wd"}, wdat, exp_wd);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({nm, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({nm, "_resp_rdata"}, resp_rdata, 32'h0);
    chk({nm, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({nm, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({nm, "_mem_a"}, mem_a, 32'h0);
    chk({nm, "_mem_wd"}, mem_wd, 32'h0);
  endtask

  initial begin
    logic [31:0] rd, wdat;
    logic        er;
    int          lat, wc, nr, waited;
    int          kk [3];
    logic [31:0] dd [3];
    logic [2:0]  pick [5];
    logic [2:0]  f3;
    logic        we;
    int          word, off;

    // reset state
    repeat (3) @(negedge clk);
    chk_quiet("rst_held");
    reset_n = 1'b1;
    @(negedge clk);
    chk_quiet("rst_release");

    // loads of word 1 with every extension mode
    dreq("sw_w1", 1'b1, 3'b010, 32'h4, 32'h8765_43F0, 32'h0, 1'b0, 2, 1, 32'h8765_43F0);
    dreq("lb",  1'b0, 3'b000, 32'h4, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, -1, 32'h0);
    dreq("lbu", 1'b0, 3'b100, 32'h4, 32'h0, 32'h0000_00F0, 1'b0, 2, -1, 32'h0);
    dreq("lh",  1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF_8765, 1'b0, 2, -1, 32'h0);
    dreq("lhu", 1'b0, 3'b101, 32'h6, 32'h0, 32'h0000_8765, 1'b0, 2, -1, 32'h0);
    dreq("lw",  1'b0, 3'b010, 32'h4, 32'h0, 32'h8765_43F0, 1'b0, 2, -1, 32'h0);

    // sub-word read-modify-write
    dreq("sw_w2", 1'b1, 3'b010, 32'h8, 32'h1122_3344, 32'h0, 1'b0, 2, 1, 32'h1122_3344);
    dreq("sb",    1'b1, 3'b000, 32'h9, 32'h1234_56AA, 32'h0, 1'b0, 3, 2, 32'h1122_AA44);
    dreq("lw_sb", 1'b0, 3'b010, 32'h8, 32'h0, 32'h1122_AA44, 1'b0, 2, -1, 32'h0);
    dreq("sw_w2b", 1'b1, 3'b010, 32'h8, 32'h1122_3344, 32'h0, 1'b0, 2, 1, 32'h1122_3344);
    dreq("sh",    1'b1, 3'b001, 32'hA, 32'h5555_BEEF, 32'h0, 1'b0, 3, 2, 32'hBEEF_3344);
    dreq("sw_w3", 1'b1, 3'b010, 32'hC, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 32'hDEAD_BEEF);

    // errors
    dreq("err_lh_mis", 1'b0, 3'b001, 32'h3,   32'h0, 32'h0, 1'b1, 1, -1, 32'h0);
    dreq("err_sw_mis", 1'b1, 3'b010, 32'h2,   32'hFFFF_FFFF, 32'h0, 1'b1, 1, -1, 32'h0);
    dreq("err_range",  1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1, 1, -1, 32'h0);
    dreq("err_f3",     1'b0, 3'b011, 32'h4,   32'h0, 32'h0, 1'b1, 1, -1, 32'h0);
    dreq("err_st_bu",  1'b1, 3'b100, 32'h4,   32'h0, 32'h0, 1'b1, 1, -1, 32'h0);
    dreq("lw_after_err", 1'b0, 3'b010, 32'h4, 32'h0, 32'h8765_43F0, 1'b0, 2, -1, 32'h0);

    // back-to-back loads with req_valid held high
    waited = 0;
    @(negedge clk);
    while (!req_ready && (waited < 20)) begin
      @(negedge clk);
      waited++;
    end
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4;
    nr = 0;
    for (int i = 0; i < 3; i++) begin
      kk[i] = -1;
      dd[i] = 32'h0;
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (resp_valid && (nr < 3)) begin
        kk[nr] = k;
        dd[nr] = resp_rdata;
        nr++;
        if (nr < 3) req_addr = 32'(4 + 4 * nr);
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_lat0", 32'(kk[0]), 32'd2);
    chk("b2b_lat1", 32'(kk[1]), 32'd5);
    chk("b2b_lat2", 32'(kk[2]), 32'd8);
    chk("b2b_data0", dd[0], 32'h8765_43F0);
    chk("b2b_data1", dd[1], 32'hBEEF_3344);
    chk("b2b_data2", dd[2], 32'hDEAD_BEEF);

    // reset asserted during the WR cycle of an SB
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'hD; req_wdata = 32'h55;
    @(negedge clk);  // RD
    req_valid = 1'b0;
    @(negedge clk);  // WR
    chk("rmw_we_before_rst", 32'(mem_we), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rmw_we_dropped", 32'(mem_we), 32'd0);
    chk("rmw_no_resp", 32'(resp_valid), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_resp", 32'(resp_valid), 32'd0);
    end
    #2 reset_n = 1'b1;
    #1;
    chk_quiet("rmw_released");
    dreq("lw_after_rst", 1'b0, 3'b010, 32'hC, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, -1, 32'h0);

    // randomized traffic, checked cycle by cycle against the model
    pick[0] = 3'b000; pick[1] = 3'b001; pick[2] = 3'b010; pick[3] = 3'b100; pick[4] = 3'b101;
    for (int n = 0; n < 250; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : pick[$urandom_range(0, 4)];
      word = int'($urandom_range(0, 67));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) off = 2 * int'($urandom_range(0, 1));
        else if (f3[1:0] == 2'b10) off = 0;
        else off = int'($urandom_range(0, 3));
      end else begin
        off = int'($urandom_range(0, 3));
      end
      do_req(we, f3, 32'(word * 4 + off), $urandom, rd, er, lat, wc, wdat);
      chk("rand_resp_seen", 32'(lat > 0), 32'd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // memory contents must match the model
    repeat (3) @(negedge clk);
    for (int i = 0; i < 64; i++) chk("mem_final", sim_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
